// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  // Address width for a register count; one-register corner kept at 1 bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int DEFAULT_AW = addr_width(DEFAULT_NREGS);

  typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
  typedef logic [DEFAULT_XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking a pending
// producer. Issue sets, writeback clears, and a same-cycle set beats a clear
// because the newly issued instruction is the one the register now waits on.
// Register 0 is never busy.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: clear on writeback first, then let an issue re-set it.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bits held in flops, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// NRD combinational read ports, NWR clocked write ports; register 0 reads 0.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = DEFAULT_XLEN,
  parameter  int NREGS = DEFAULT_NREGS,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_vec  (busy_vec)
  );

  // Next storage state: ports applied in index order so the younger port wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Register storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; with bypass, an in-flight write overrides stored state.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy_vec[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (reset_n && wr_en[j] && (rd_addr[i*AW +: AW] != '0) &&
            (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_busy[i]              = iss_valid && (iss_rd == rd_addr[i*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp. The driver updates an
// architectural model after each edge, then pushes the expected read-port
// view for the new inputs; a negedge monitor pops and compares.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic [NREGS-1:0]    busy_vec;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Architectural model: plain arrays of register values and pending flags.
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  typedef struct packed {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic [NREGS-1:0]    bvec;
  } exp_t;

  exp_t exp_q [$];

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  // Shared comparison: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Apply the edge that just happened to the model, using the inputs that
  // were held across it: writes in port order, then an issue overrides.
  task automatic advanceModel();
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  // Expected read-port view for the inputs currently driven.
  task automatic pushExpect();
    exp_t e;
    logic [AW-1:0] a;
    e = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (reset_n) begin
        e.data[i*XLEN +: XLEN] = (a == 0) ? '0 : m_regs[a];
        e.busy[i]              = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && a != 0 && wr_addr[j*AW +: AW] == a) begin
            e.data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            e.busy[i]              = iss_valid && (iss_rd == a);
          end
        end
`endif
      end
    end
    e.bvec = reset_n ? m_busy : '0;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, driven 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rn, input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    advanceModel();
    reset_n   = rn;
    wr_en     = we;
    wr_addr   = {wa1, wa0};
    wr_data   = {wd1, wd0};
    iss_valid = iv;
    iss_rd    = ird;
    rd_addr   = {ra1, ra0};
    pushExpect();
  endtask

  // Idle cycle reading two registers.
  task automatic readRegs(input logic rn, input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(rn, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
  endtask

  // Monitor: the read ports are always presenting, so one pop per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("rd_data0", rd_data[XLEN-1:0], e.data[XLEN-1:0]);
      checkOutput("rd_data1", rd_data[2*XLEN-1:XLEN], e.data[2*XLEN-1:XLEN]);
      checkOutput("rd_busy", {30'b0, rd_busy}, {30'b0, e.busy});
      checkOutput("busy_vec", busy_vec, e.bvec);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    m_busy = '0;

    // Reset held: every address on every port reads zero and idle.
    for (int a = 0; a < NREGS; a++) begin
      readRegs(1'b0, 5'(a), 5'(NREGS - 1 - a));
    end
    #1 checkOutput("reset_busy_vec", busy_vec, 32'd0);

    readRegs(1'b1, 5'd0, 5'd0);

    // x1 = 100, then read it on both ports.
    applyStimulus(1'b1, 2'b01, 5'd1, 32'd100, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    readRegs(1'b1, 5'd1, 5'd1);
    #1 checkOutput("x1_port0", rd_data[XLEN-1:0], 32'd100);
    checkOutput("x1_port1", rd_data[2*XLEN-1:XLEN], 32'd100);

    // Write to x0 is dropped.
    applyStimulus(1'b1, 2'b01, 5'd0, 32'd999, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    readRegs(1'b1, 5'd0, 5'd0);
    #1 checkOutput("x0_zero", rd_data[XLEN-1:0], 32'd0);

    // Same-address dual write: port 1 wins.
    applyStimulus(1'b1, 2'b11, 5'd5, 32'hAAAA_AAAA, 5'd5, 32'h5555_5555, 1'b0, 5'd0, 5'd0, 5'd0);
    readRegs(1'b1, 5'd5, 5'd1);
    #1 checkOutput("x5_port1_wins", rd_data[XLEN-1:0], 32'h5555_5555);

    // Issue x3, then write x3 = 7 while re-issuing x3: stays busy.
    applyStimulus(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    applyStimulus(1'b1, 2'b01, 5'd3, 32'd7, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    #1 checkOutput("x3_busy_after_issue", {31'b0, rd_busy[0]}, 32'd1);
    readRegs(1'b1, 5'd3, 5'd0);
    #1 checkOutput("x3_busy_set_wins", {31'b0, rd_busy[0]}, 32'd1);
    checkOutput("x3_data", rd_data[XLEN-1:0], 32'd7);

    // Write x2 = 200 while reading x2.
    applyStimulus(1'b1, 2'b01, 5'd2, 32'd200, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd0);
`ifdef REGFILE_BYPASS_EN
    #1 checkOutput("x2_same_cycle", rd_data[XLEN-1:0], 32'd200);
`else
    #1 checkOutput("x2_same_cycle", rd_data[XLEN-1:0], 32'd0);
`endif
    checkOutput("x2_not_busy", {31'b0, rd_busy[0]}, 32'd0);
    readRegs(1'b1, 5'd2, 5'd0);
    #1 checkOutput("x2_next_cycle", rd_data[XLEN-1:0], 32'd200);

    // Reset asserted between edges clears state with no clock.
    readRegs(1'b1, 5'd1, 5'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_data0", rd_data[XLEN-1:0], 32'd0);
    checkOutput("async_rst_busy1", {31'b0, rd_busy[1]}, 32'd0);
    checkOutput("async_rst_busy_vec", busy_vec, 32'd0);
    readRegs(1'b0, 5'd1, 5'd3);
    readRegs(1'b0, 5'd5, 5'd2);
    readRegs(1'b1, 5'd1, 5'd3);

    // Random traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'b1, 2'($urandom),
                    5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    readRegs(1'b1, 5'd0, 5'd0);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
